// File: rtl/miriscv_alu_mc.sv
// rtl/miriscv_alu_mc.sv - multi-cycle integer ALU with iterative unsigned multiply/divide
//
// Purpose:
//    Executes base ALU and compare operations in one registered cycle. Executes MUL,
//    MULHU, DIVU and REMU iteratively, one bit per cycle. Requests use a
//    req/ready/valid handshake.
//
// Ports:
//    clk_i               clock, rising edge
//    arstn_i             asynchronous active-low reset
//    req_i / ready_o     request handshake, accepted when req_i && ready_o && !kill_i
//    kill_i              abort the in-flight multi-cycle op; blocks an accept in IDLE
//    operator_i          operation code, sampled on accept
//    operand_a_i/_b_i    operands, sampled on accept
//    valid_o             one-cycle result pulse
//    result_o            operation result, held between pulses
//    comparison_result_o branch-condition flag, held between pulses
module miriscv_alu_mc #(
   parameter int WIDTH = 32,
   parameter int OP_W  = 7
) (
   input  logic             clk_i,
   input  logic             arstn_i,
   input  logic             req_i,
   output logic             ready_o,
   input  logic             kill_i,
   input  logic [OP_W-1:0]  operator_i,
   input  logic [WIDTH-1:0] operand_a_i,
   input  logic [WIDTH-1:0] operand_b_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] result_o,
   output logic             comparison_result_o
);

   localparam int SHW   = $clog2(WIDTH);
   localparam int CNT_W = $clog2(WIDTH);

   localparam logic [OP_W-1:0] ALU_ADD   = OP_W'(7'b0011000);
   localparam logic [OP_W-1:0] ALU_SUB   = OP_W'(7'b0011001);
   localparam logic [OP_W-1:0] ALU_XOR   = OP_W'(7'b0101111);
   localparam logic [OP_W-1:0] ALU_OR    = OP_W'(7'b0101110);
   localparam logic [OP_W-1:0] ALU_AND   = OP_W'(7'b0010101);
   localparam logic [OP_W-1:0] ALU_SRA   = OP_W'(7'b0100100);
   localparam logic [OP_W-1:0] ALU_SRL   = OP_W'(7'b0100101);
   localparam logic [OP_W-1:0] ALU_SLL   = OP_W'(7'b0100111);
   localparam logic [OP_W-1:0] ALU_LTS   = OP_W'(7'b0000000);
   localparam logic [OP_W-1:0] ALU_LTU   = OP_W'(7'b0000001);
   localparam logic [OP_W-1:0] ALU_GES   = OP_W'(7'b0001010);
   localparam logic [OP_W-1:0] ALU_GEU   = OP_W'(7'b0001011);
   localparam logic [OP_W-1:0] ALU_EQ    = OP_W'(7'b0001100);
   localparam logic [OP_W-1:0] ALU_NE    = OP_W'(7'b0001101);
   localparam logic [OP_W-1:0] ALU_MUL   = OP_W'(7'b1000000);
   localparam logic [OP_W-1:0] ALU_MULHU = OP_W'(7'b1000011);
   localparam logic [OP_W-1:0] ALU_DIVU  = OP_W'(7'b1000101);
   localparam logic [OP_W-1:0] ALU_REMU  = OP_W'(7'b1000111);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_mcand;   // multiplicand (MUL) or divisor (DIV), constant during the op
   logic [WIDTH-1:0] r_shift;   // multiplier -> product low half (MUL); dividend -> quotient (DIV)
   logic [WIDTH-1:0] r_hi;      // product high half (MUL) or partial remainder (DIV)
   logic             r_sel_hi;  // MULHU/REMU return r_hi, MUL/DIVU return r_shift
   logic [WIDTH-1:0] r_result;
   logic             r_cmp;
   logic             r_valid;

   logic             w_accept;
   logic             w_is_mul;
   logic             w_is_div;
   logic [WIDTH-1:0] w_alu_result;
   logic             w_flag;
   logic             w_is_cmp;
   logic [SHW-1:0]   w_shamt;
   logic [WIDTH:0]   w_mul_sum;
   logic [WIDTH:0]   w_div_trial;
   logic [WIDTH:0]   w_div_diff;

   assign ready_o             = (r_state == S_IDLE);
   assign valid_o             = r_valid;
   assign result_o            = r_result;
   assign comparison_result_o = r_cmp;

   assign w_accept = req_i && ready_o && !kill_i;
   assign w_is_mul = (operator_i == ALU_MUL)  || (operator_i == ALU_MULHU);
   assign w_is_div = (operator_i == ALU_DIVU) || (operator_i == ALU_REMU);
   assign w_shamt  = operand_b_i[SHW-1:0];

   // LSB-first shift-add: the sum's low bit drops into the vacated top of r_shift,
   // so {r_hi, r_shift} becomes the full product after WIDTH steps.
   assign w_mul_sum = {1'b0, r_hi} + (r_shift[0] ? {1'b0, r_mcand} : '0);

   // Restoring division: a non-negative difference (MSB clear) means subtract succeeds.
   // A zero divisor always succeeds, yielding all-ones quotient and remainder = dividend.
   assign w_div_trial = {r_hi, r_shift[WIDTH-1]};
   assign w_div_diff  = w_div_trial - {1'b0, r_mcand};

   always_comb begin
      w_alu_result = '0;
      w_flag       = 1'b0;
      w_is_cmp     = 1'b0;
      case (operator_i)
         ALU_ADD: w_alu_result = operand_a_i + operand_b_i;
         ALU_SUB: w_alu_result = operand_a_i - operand_b_i;
         ALU_XOR: w_alu_result = operand_a_i ^ operand_b_i;
         ALU_OR:  w_alu_result = operand_a_i | operand_b_i;
         ALU_AND: w_alu_result = operand_a_i & operand_b_i;
         ALU_SRA: w_alu_result = $unsigned($signed(operand_a_i) >>> w_shamt);
         ALU_SRL: w_alu_result = operand_a_i >> w_shamt;
         ALU_SLL: w_alu_result = operand_a_i << w_shamt;
         ALU_LTS: begin w_is_cmp = 1'b1; w_flag = $signed(operand_a_i) <  $signed(operand_b_i); end
         ALU_LTU: begin w_is_cmp = 1'b1; w_flag = operand_a_i <  operand_b_i; end
         ALU_GES: begin w_is_cmp = 1'b1; w_flag = $signed(operand_a_i) >= $signed(operand_b_i); end
         ALU_GEU: begin w_is_cmp = 1'b1; w_flag = operand_a_i >= operand_b_i; end
         ALU_EQ:  begin w_is_cmp = 1'b1; w_flag = operand_a_i == operand_b_i; end
         ALU_NE:  begin w_is_cmp = 1'b1; w_flag = operand_a_i != operand_b_i; end
         default: w_alu_result = '0;
      endcase
      if (w_is_cmp) begin
         w_alu_result = {{(WIDTH-1){1'b0}}, w_flag};
      end
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_mcand  <= '0;
         r_shift  <= '0;
         r_hi     <= '0;
         r_sel_hi <= 1'b0;
         r_result <= '0;
         r_cmp    <= 1'b0;
         r_valid  <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (w_is_mul) begin
                     r_mcand  <= operand_a_i;
                     r_shift  <= operand_b_i;
                     r_hi     <= '0;
                     r_sel_hi <= (operator_i == ALU_MULHU);
                     r_cnt    <= CNT_W'(WIDTH-1);
                     r_state  <= S_MUL;
                  end else if (w_is_div) begin
                     r_mcand  <= operand_b_i;
                     r_shift  <= operand_a_i;
                     r_hi     <= '0;
                     r_sel_hi <= (operator_i == ALU_REMU);
                     r_cnt    <= CNT_W'(WIDTH-1);
                     r_state  <= S_DIV;
                  end else begin
                     r_result <= w_alu_result;
                     r_cmp    <= w_flag;
                     r_valid  <= 1'b1;
                  end
               end
            end
            S_MUL: begin
               if (kill_i) begin
                  r_state <= S_IDLE;
               end else begin
                  r_hi    <= w_mul_sum[WIDTH:1];
                  r_shift <= {w_mul_sum[0], r_shift[WIDTH-1:1]};
                  r_cnt   <= r_cnt - 1'b1;
                  if (r_cnt == '0) r_state <= S_DONE;
               end
            end
            S_DIV: begin
               if (kill_i) begin
                  r_state <= S_IDLE;
               end else begin
                  if (!w_div_diff[WIDTH]) begin
                     r_hi    <= w_div_diff[WIDTH-1:0];
                     r_shift <= {r_shift[WIDTH-2:0], 1'b1};
                  end else begin
                     r_hi    <= w_div_trial[WIDTH-1:0];
                     r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                  end
                  r_cnt <= r_cnt - 1'b1;
                  if (r_cnt == '0) r_state <= S_DONE;
               end
            end
            default: begin
               // S_DONE: a kill here drops the result and keeps the previous outputs
               r_state <= S_IDLE;
               if (!kill_i) begin
                  r_result <= r_sel_hi ? r_hi : r_shift;
                  r_cmp    <= 1'b0;
                  r_valid  <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule
